// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - Instruction ID encoding (shared with decode)
//   - FSM state type
//   - Holding-register and MEM_WB payload structs
//   - Load/store/misalignment decode helpers
package mem_stage_pkg;

  localparam logic [5:0] InstrNop = 6'd0;
  localparam logic [5:0] InstrAdd = 6'd1;
  localparam logic [5:0] InstrSub = 6'd2;
  localparam logic [5:0] InstrAnd = 6'd3;
  localparam logic [5:0] InstrOr  = 6'd4;
  localparam logic [5:0] InstrLb  = 6'd16;
  localparam logic [5:0] InstrLh  = 6'd17;
  localparam logic [5:0] InstrLw  = 6'd18;
  localparam logic [5:0] InstrLbu = 6'd19;
  localparam logic [5:0] InstrLhu = 6'd20;
  localparam logic [5:0] InstrSb  = 6'd21;
  localparam logic [5:0] InstrSh  = 6'd22;
  localparam logic [5:0] InstrSw  = 6'd23;

  typedef enum logic [1:0] {StIdle, StReq, StResp} mem_state_e;

  // Memory instruction captured on acceptance, drives the bus and completion.
  typedef struct packed {
    logic        rd_valid;
    logic [4:0]  rd_addr;
    logic [31:0] rd_value;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [5:0]  instr_id;
  } hold_t;

  // Registered MEM_WB payload.
  typedef struct packed {
    logic        valid;
    logic        rd_valid;
    logic [4:0]  rd_addr;
    logic [31:0] rd_value;
    logic [31:0] mem_data;
    logic [5:0]  instr_id;
    logic        misaligned;
    logic        bus_err;
  } wb_t;

  function automatic logic is_load(input logic [5:0] id);
    return (id == InstrLb) || (id == InstrLh) || (id == InstrLw) ||
           (id == InstrLbu) || (id == InstrLhu);
  endfunction

  function automatic logic is_store(input logic [5:0] id);
    return (id == InstrSb) || (id == InstrSh) || (id == InstrSw);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] id, input logic [1:0] addr_lo);
    logic half, word;
    half = (id == InstrLh) || (id == InstrLhu) || (id == InstrSh);
    word = (id == InstrLw) || (id == InstrSw);
    return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load lane alignment and extension.
//   rdata_i    : raw 32-bit word from data memory
//   offset_i   : byte offset within the word (addr[1:0])
//   instr_id_i : load instruction ID selecting width and signedness
//   data_o     : aligned, extended load result
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [5:0]  instr_id_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (instr_id_i)
      InstrLb:  data_o = {{24{byte_sel[7]}}, byte_sel};
      InstrLbu: data_o = {24'b0, byte_sel};
      InstrLh:  data_o = {{16{half_sel[15]}}, half_sel};
      InstrLhu: data_o = {16'b0, half_sel};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU ops through in one cycle, runs loads/stores
// over a valid/ready request + response data bus with a response timeout.
//   clk, rst_n                 : clock, async active-low reset
//   valid_in .. instr_id_in    : EX_MEM payload; stall_out holds it upstream
//   dmem_req_* / dmem_addr ... : data-memory request channel
//   dmem_rsp_valid, dmem_rdata : data-memory response (load data / store ack)
//   *_out                      : registered MEM_WB payload
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        rd_valid_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] rd_value_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] store_data_in,
  input  logic [5:0]  instr_id_in,
  output logic        stall_out,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic        rd_valid_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_value_out,
  output logic [31:0] mem_data_out,
  output logic [5:0]  instr_id_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  mem_state_e      state_q, state_d;
  hold_t           hold_q, hold_d;
  wb_t             wb_q, wb_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic [31:0]     load_data;
  logic            in_mem, in_misaligned, hold_load, req_active;

  load_align u_load_align (
    .rdata_i    (dmem_rdata),
    .offset_i   (hold_q.mem_addr[1:0]),
    .instr_id_i (hold_q.instr_id),
    .data_o     (load_data)
  );

  assign in_mem        = is_load(instr_id_in) | is_store(instr_id_in);
  assign in_misaligned = in_mem & is_misaligned(instr_id_in, mem_addr_in[1:0]);
  assign hold_load     = is_load(hold_q.instr_id);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    wait_d   = wait_q;
    wb_d     = wb_q;
    wb_d.valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          if (!in_mem || in_misaligned) begin
            // ALU ops and misaligned accesses complete without touching the bus.
            wb_d.valid      = 1'b1;
            wb_d.rd_valid   = rd_valid_in & ~in_misaligned;
            wb_d.rd_addr    = rd_addr_in;
            wb_d.rd_value   = rd_value_in;
            wb_d.mem_data   = '0;
            wb_d.instr_id   = instr_id_in;
            wb_d.misaligned = in_misaligned;
            wb_d.bus_err    = 1'b0;
          end else begin
            hold_d = '{rd_valid:   rd_valid_in,
                       rd_addr:    rd_addr_in,
                       rd_value:   rd_value_in,
                       mem_addr:   mem_addr_in,
                       store_data: store_data_in,
                       instr_id:   instr_id_in};
            state_d = StReq;
          end
        end
      end
      StReq: begin
        wait_d = '0;
        if (dmem_req_ready) state_d = StResp;
      end
      StResp: begin
        if (dmem_rsp_valid || (wait_q == CntW'(MAX_WAIT - 1))) begin
          // Response or timeout; a timeout drops the register write.
          wb_d.valid      = 1'b1;
          wb_d.rd_valid   = hold_q.rd_valid & hold_load & dmem_rsp_valid;
          wb_d.rd_addr    = hold_q.rd_addr;
          wb_d.rd_value   = hold_q.rd_value;
          wb_d.mem_data   = (hold_load && dmem_rsp_valid) ? load_data : '0;
          wb_d.instr_id   = hold_q.instr_id;
          wb_d.misaligned = 1'b0;
          wb_d.bus_err    = ~dmem_rsp_valid;
          wait_d          = '0;
          state_d         = StIdle;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      wb_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wb_q    <= wb_d;
      wait_q  <= wait_d;
    end
  end

  // Bus payload is driven only in REQ so it reads as zero elsewhere.
  assign req_active = (state_q == StReq);

  always_comb begin
    dmem_req_valid = req_active;
    dmem_addr      = req_active ? {hold_q.mem_addr[31:2], 2'b00} : '0;
    dmem_we        = req_active & is_store(hold_q.instr_id);
    dmem_wstrb     = '0;
    dmem_wdata     = '0;
    if (req_active) begin
      case (hold_q.instr_id)
        InstrSb: begin
          dmem_wstrb = 4'b0001 << hold_q.mem_addr[1:0];
          dmem_wdata = {4{hold_q.store_data[7:0]}};
        end
        InstrSh: begin
          dmem_wstrb = hold_q.mem_addr[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{hold_q.store_data[15:0]}};
        end
        InstrSw: begin
          dmem_wstrb = 4'b1111;
          dmem_wdata = hold_q.store_data;
        end
        default: ;
      endcase
    end
  end

  assign stall_out      = (state_q != StIdle);
  assign valid_out      = wb_q.valid;
  assign rd_valid_out   = wb_q.rd_valid;
  assign rd_addr_out    = wb_q.rd_addr;
  assign rd_value_out   = wb_q.rd_value;
  assign mem_data_out   = wb_q.mem_data;
  assign instr_id_out   = wb_q.instr_id;
  assign misaligned_out = wb_q.misaligned;
  assign bus_err_out    = wb_q.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios then randomized
// transactions checked against a transaction-level reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MaxWait = 15;

  logic        clk, rst_n;
  logic        valid_in, rd_valid_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] rd_value_in, mem_addr_in, store_data_in;
  logic [5:0]  instr_id_in;
  logic        stall_out, dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        valid_out, rd_valid_out, misaligned_out, bus_err_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_value_out, mem_data_out;
  logic [5:0]  instr_id_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_val;
  logic [5:0]  last_id;

  mem_stage #(.MAX_WAIT(MaxWait)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in),
    .rd_value_in(rd_value_in), .mem_addr_in(mem_addr_in), .store_data_in(store_data_in),
    .instr_id_in(instr_id_in), .stall_out(stall_out),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .valid_out(valid_out), .rd_valid_out(rd_valid_out), .rd_addr_out(rd_addr_out),
    .rd_value_out(rd_value_out), .mem_data_out(mem_data_out),
    .instr_id_out(instr_id_out), .misaligned_out(misaligned_out),
    .bus_err_out(bus_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_load(input logic [5:0] id);
    return id == InstrLb || id == InstrLh || id == InstrLw || id == InstrLbu || id == InstrLhu;
  endfunction

  function automatic bit m_store(input logic [5:0] id);
    return id == InstrSb || id == InstrSh || id == InstrSw;
  endfunction

  function automatic bit m_misaligned(input logic [5:0] id, input logic [31:0] addr);
    if (id == InstrLh || id == InstrLhu || id == InstrSh) return (addr % 2) != 0;
    if (id == InstrLw || id == InstrSw) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load_data(input logic [5:0] id, input logic [31:0] addr,
                                              input logic [31:0] rdata);
    longint v;
    int unsigned off;
    logic [31:0] sh;
    off = addr % 4;
    if (id == InstrLb || id == InstrLbu) begin
      sh = rdata >> (8 * off);
      v = sh % 256;
      if (id == InstrLb && v >= 128) v = v - 256;
    end else if (id == InstrLh || id == InstrLhu) begin
      sh = rdata >> (16 * (off / 2));
      v = sh % 65536;
      if (id == InstrLh && v >= 32768) v = v - 65536;
    end else begin
      v = rdata;
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [5:0] id, input logic [31:0] addr);
    if (id == InstrSb) return 4'(1 << (addr % 4));
    if (id == InstrSh) return ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] id, input logic [31:0] d);
    if (id == InstrSb) return (d % 256) * 32'h0101_0101;
    if (id == InstrSh) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // One instruction from acceptance to completion with a scripted memory.
  // rsp_lat >= MaxWait means the memory never answers.
  task automatic do_op(input logic [5:0] id, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic rdv, input logic [4:0] rda, input logic [31:0] rval,
                       input logic [31:0] rdata, input int rdy_lat, input int rsp_lat);
    bit ld, st, mis;
    ld  = m_load(id);
    st  = m_store(id);
    mis = m_misaligned(id, addr);
    chk("idle_stall", stall_out, 0);
    valid_in = 1'b1; instr_id_in = id; mem_addr_in = addr; store_data_in = sdata;
    rd_valid_in = rdv; rd_addr_in = rda; rd_value_in = rval;
    step();
    // Scramble upstream so the stage must rely on its own captured copy.
    valid_in = 1'b0; rd_value_in = $urandom; mem_addr_in = $urandom;
    store_data_in = $urandom; rd_addr_in = 5'($urandom); rd_valid_in = 1'($urandom);
    instr_id_in = InstrLw;
    if (!(ld || st) || mis) begin
      chk("direct_valid", valid_out, 1);
      chk("direct_misal", misaligned_out, 32'(mis));
      chk("direct_rdvalid", rd_valid_out, 32'(rdv && !mis));
      chk("direct_rdaddr", rd_addr_out, 32'(rda));
      chk("direct_rdvalue", rd_value_out, rval);
      chk("direct_id", instr_id_out, 32'(id));
      chk("direct_buserr", bus_err_out, 0);
      chk("direct_noreq", dmem_req_valid, 0);
      chk("direct_stall", stall_out, 0);
      last_val = rval; last_id = id;
      return;
    end
    chk("accept_valid", valid_out, 0);
    chk("accept_stall", stall_out, 1);
    for (int i = 0; i <= rdy_lat; i++) begin
      chk("req_valid", dmem_req_valid, 1);
      chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      chk("req_we", dmem_we, 32'(st));
      if (st) begin
        chk("req_wstrb", dmem_wstrb, 32'(m_wstrb(id, addr)));
        chk("req_wdata", dmem_wdata, m_wdata(id, sdata));
      end
      if (i == rdy_lat) begin
        dmem_req_ready = 1'b1;
      end else begin
        // Stray responses while requesting must be ignored.
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'($urandom); dmem_rdata = $urandom;
      end
      step();
      dmem_rsp_valid = 1'b0;
      chk("req_novalid", valid_out, 0);
    end
    dmem_req_ready = 1'b0;
    chk("resp_noreq", dmem_req_valid, 0);
    chk("resp_stall", stall_out, 1);
    if (rsp_lat < MaxWait) begin
      for (int i = 0; i < rsp_lat; i++) begin
        step();
        chk("resp_wait", valid_out, 0);
      end
      dmem_rsp_valid = 1'b1; dmem_rdata = rdata;
      step();
      dmem_rsp_valid = 1'b0; dmem_rdata = $urandom;
      chk("done_valid", valid_out, 1);
      chk("done_buserr", bus_err_out, 0);
      chk("done_misal", misaligned_out, 0);
      chk("done_rdvalid", rd_valid_out, 32'(rdv && ld));
      chk("done_rdaddr", rd_addr_out, 32'(rda));
      chk("done_rdvalue", rd_value_out, rval);
      chk("done_id", instr_id_out, 32'(id));
      chk("done_stall", stall_out, 0);
      if (ld) chk("done_memdata", mem_data_out, m_load_data(id, addr, rdata));
    end else begin
      for (int i = 0; i < MaxWait; i++) begin
        step();
        if (i < MaxWait - 1) chk("timeout_wait", valid_out, 0);
      end
      chk("timeout_valid", valid_out, 1);
      chk("timeout_buserr", bus_err_out, 1);
      chk("timeout_rdvalid", rd_valid_out, 0);
      chk("timeout_misal", misaligned_out, 0);
      chk("timeout_idle", stall_out, 0);
    end
    last_val = rval; last_id = id;
  endtask

  // Idle cycle with a stray response: outputs must hold, valid_out low.
  task automatic idle_gap();
    dmem_rsp_valid = 1'($urandom); dmem_rdata = $urandom;
    step();
    dmem_rsp_valid = 1'b0;
    chk("gap_valid", valid_out, 0);
    chk("gap_hold_value", rd_value_out, last_val);
    chk("gap_hold_id", instr_id_out, 32'(last_id));
    chk("gap_stall", stall_out, 0);
  endtask

  logic [5:0] ids [11];

  initial begin
    ids = '{InstrAdd, InstrSub, InstrLb, InstrLh, InstrLw, InstrLbu, InstrLhu,
            InstrSb, InstrSh, InstrSw, InstrOr};
    rst_n = 1'b0; valid_in = 1'b0; rd_valid_in = 1'b0; rd_addr_in = '0;
    rd_value_in = '0; mem_addr_in = '0; store_data_in = '0; instr_id_in = InstrNop;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    last_val = '0; last_id = '0;
    step(); step();
    chk("rst_valid", valid_out, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_req", dmem_req_valid, 0);
    chk("rst_rdvalue", rd_value_out, 0);
    chk("rst_memdata", mem_data_out, 0);
    rst_n = 1'b1;
    step();

    // Directed scenarios
    do_op(InstrAdd, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1234, 32'h0, 0, 0);
    idle_gap();
    do_op(InstrLb, 32'h103, 32'h0, 1'b1, 5'd4, 32'h103, 32'h80FF_FF7F, 0, 0);
    idle_gap();
    do_op(InstrSh, 32'h202, 32'h0000_ABCD, 1'b1, 5'd5, 32'h202, 32'h0, 0, 0);
    idle_gap();
    do_op(InstrLw, 32'h301, 32'h0, 1'b1, 5'd6, 32'h301, 32'h0, 0, 0);
    idle_gap();
    do_op(InstrLw, 32'h400, 32'h0, 1'b1, 5'd7, 32'h400, 32'h0, 4, MaxWait);
    idle_gap();

    // Reset while waiting for a response, then a late response.
    valid_in = 1'b1; instr_id_in = InstrLw; mem_addr_in = 32'h500; rd_valid_in = 1'b1;
    rd_value_in = 32'h77; step();
    valid_in = 1'b0; dmem_req_ready = 1'b1; step();
    dmem_req_ready = 1'b0; step();
    chk("pre_rst_stall", stall_out, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", stall_out, 0);
    chk("async_rst_req", dmem_req_valid, 0);
    chk("async_rst_rdvalue", rd_value_out, 0);
    chk("async_rst_id", instr_id_out, 0);
    chk("async_rst_buserr", bus_err_out, 0);
    step();
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_rsp_valid = 1'b0;
    chk("late_rsp_valid", valid_out, 0);
    chk("late_rsp_memdata", mem_data_out, 0);
    chk("late_rsp_stall", stall_out, 0);
    last_val = '0; last_id = '0;
    do_op(InstrAdd, 32'h0, 32'h0, 1'b1, 5'd9, 32'h5555_AAAA, 32'h0, 0, 0);
    idle_gap();

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      int rsp;
      rsp = ($urandom_range(0, 7) == 0) ? MaxWait : int'($urandom_range(0, 3));
      do_op(ids[$urandom_range(0, 10)], $urandom, $urandom, 1'($urandom), 5'($urandom),
            $urandom, $urandom, int'($urandom_range(0, 3)), rsp);
      idle_gap();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MAX_WAIT, 15, number of RESP-state cycles without dmem_rsp_valid before a bus timeout is declared.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 valid_in, rd_valid_in  in  1 each  instruction valid and destination-write flag from EX_MEM.
REQ-005 rd_addr_in  in  5;  rd_value_in  in  32 (ALU result);  mem_addr_in  in  32;  store_data_in  in  32;  instr_id_in  in  6 (instr_defines.vh encoding).
REQ-006 stall_out  out  1  input not accepted this cycle; upstream SHALL hold its inputs stable.
REQ-007 dmem_req_valid  out  1;  dmem_req_ready  in  1;  dmem_addr  out  32 (word aligned);  dmem_we  out  1;  dmem_wstrb  out  4;  dmem_wdata  out  32.
REQ-008 dmem_rsp_valid  in  1;  dmem_rdata  in  32  (load data or store acknowledge).
REQ-009 Registered MEM_WB outputs: valid_out 1, rd_valid_out 1, rd_addr_out 5, rd_value_out 32, mem_data_out 32, instr_id_out 6, misaligned_out 1, bus_err_out 1.

Function
REQ-010 FSM states are IDLE, REQ and RESP; stall_out SHALL equal (state != IDLE).
REQ-011 In IDLE with valid_in=1 and a non-memory instruction, the stage SHALL register the inputs into the outputs at the next edge with valid_out=1, giving 1-cycle latency and 1 instruction/cycle throughput.
REQ-012 In IDLE with an aligned load or store (LB, LH, LW, LBU, LHU, SB, SH, SW), the stage SHALL capture it into a holding register, enter REQ, and emit valid_out=0.
REQ-013 Misalignment rule: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL issue no bus request and SHALL complete next edge with valid_out=1, misaligned_out=1 and rd_valid_out=0.
REQ-014 In REQ, dmem_req_valid=1 with payload from the holding register; the payload SHALL be stable until dmem_req_ready=1, which moves the FSM to RESP.
REQ-015 dmem_addr SHALL be {addr[31:2],2'b00}; dmem_we SHALL be 1 for stores.
REQ-016 Store lane mapping:
- SB: wstrb=1<<addr[1:0], byte replicated ×4.
- SH: wstrb=0011 or 1100 per addr[1], halfword replicated ×2.
- SW: wstrb=1111.
REQ-017 dmem_rsp_valid SHALL be sampled only in RESP; a response in any other state SHALL be ignored.
REQ-018 In RESP with dmem_rsp_valid=1, the stage SHALL complete: register outputs with valid_out=1 and return to IDLE.
REQ-019 Load data SHALL be extracted at byte offset addr[1:0] (halfword at addr[1]) from dmem_rdata; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; the result SHALL appear on mem_data_out.
REQ-020 Stores SHALL complete with rd_valid_out=0 regardless of rd_valid_in.
REQ-021 After MAX_WAIT RESP cycles without a response, the stage SHALL complete with bus_err_out=1, rd_valid_out=0 and return to IDLE.
REQ-022 Every completed output SHALL carry rd_valid_out = rd_valid_in & no error; misaligned_out and bus_err_out SHALL be 0 on non-error completions.
REQ-023 On cycles without completion, valid_out=0 and the other outputs SHALL hold their previous values.
REQ-024 Best-case load latency (dmem_req_ready=1, response 1 cycle later) SHALL be 3 cycles from acceptance to valid_out.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, zero all outputs including dmem_req_valid, and clear the timeout counter and holding register, including mid-transaction.
REQ-026 A response arriving after reset release for an abandoned request SHALL be ignored per REQ-017.

Structure
REQ-027 Instruction IDs come from instr_defines.vh; FSM state encodings and the is_load/is_store decode helpers SHALL live in a shared package.
REQ-028 Lane alignment and extension SHALL be one combinational sub-module, load_align (rdata, offset, instr_id -> data).

Verification
REQ-029 ADD (valid_in=1, rd_value_in=0x1234) -> next cycle valid_out=1, rd_value_out=0x1234, stall_out=0 throughout.
REQ-030 LB addr 0x103, dmem_rdata=0x80FF_FF7F, immediate ready and response -> mem_data_out=0xFFFFFF80; dmem_addr=0x100; valid_out 3 cycles after acceptance.
REQ-031 SH addr 0x202, data 0x0000ABCD -> wstrb=1100, wdata=0xABCDABCD, rd_valid_out=0.
REQ-032 LW addr 0x301 -> no dmem_req_valid, misaligned_out=1, rd_valid_out=0 next cycle.
REQ-033 dmem_req_ready low 4 cycles, then no response for 15 cycles -> request held stable, bus_err_out=1, FSM back in IDLE.
REQ-034 rst_n asserted in RESP, late dmem_rsp_valid after release -> all outputs 0, response ignored, next ADD completes normally.
